xy_to_angle_iter: RTL and testbench
===================================

Name: xy_to_angle_iter

Overview:
- Inverse of the angle-to-XY CORDIC path: takes a signed Cartesian pair (X, Y) and returns phase angle and magnitude, using vectoring-mode CORDIC.
- Single shared iterative datapath: one micro-rotation per clock, sequenced by an FSM.
- Valid/ready handshake on both sides.
- Sits after the rotation pipeline or any I/Q source, for phase and amplitude recovery.

Parameters:
- DSIZE, 16: input X/Y width (signed) and angle width (unsigned).
- PSIZE, 5: iteration counter width.
- ISIZE, 14: number of micro-rotations. Legal range 1..16, and ISIZE <= 2**PSIZE.

Ports:
- clock, input, 1: sole clock; all logic on rising edge.
- rst, input, 1: reset, synchronous, active-high.
- in_valid, input, 1: X/Y valid.
- in_ready, output, 1: block can accept a sample.
- X, input, DSIZE: signed two's-complement X.
- Y, input, DSIZE: signed two's-complement Y.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts result.
- Angle, output, DSIZE: unsigned phase; full circle = 2**DSIZE, 0 = +X axis, counter-clockwise positive.
- Mag, output, DSIZE+1: unsigned magnitude, including CORDIC gain K.

Behaviour:
- Reset (rst high at clock edge) forces:
  - state IDLE, in_ready=1, out_valid=0, Angle=0, Mag=0, iteration counter=0.
  - Reset overrides any in-flight operation; the partial result is discarded with no output.
- Internal x/y registers are signed DSIZE+2 bits; z register is DSIZE bits and wraps modulo 2**DSIZE.
- FSM states: IDLE, ITER, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE:
  - On in_valid & in_ready, capture with quadrant pre-rotation:
    - X>=0: x=X, y=Y, z=0.
    - X<0: x=-X, y=-Y, z=2**(DSIZE-1).
  - Sign-extend before negating, so X=-2**(DSIZE-1) is exact.
  - Clear counter i=0 and go to ITER.
- ITER, each cycle:
  - y>=0: x+=y>>>i, y-=x>>>i, z+=ATAN[i].
  - y<0: x-=y>>>i, y+=x>>>i, z-=ATAN[i].
  - Right-hand sides use the old register values (simultaneous update); shifts are arithmetic.
  - Increment i. When i==ISIZE-1 is processed, go to DONE and load Angle=z and Mag=x[DSIZE:0].
- ATAN[i] = round(atan(2**-i)/(2*pi) * 2**DSIZE). Derive it from a 32-bit constant ROM by right shift (32-DSIZE) with round-half-up. 32-bit values, i=0..15:
  - 536870912, 316933406, 167458907, 85004756, 42667331, 21354465, 10679838, 5340245,
  - 1335087 is i=9; i=8 is 2670163; then i=10 667544, 333772, 166886, 83443, 41722, 20861.
- Zero input (X==0 and Y==0) is detected at capture. The result must be Angle=0, Mag=0; the iterations still run, so latency is unchanged.
- DONE:
  - Angle and Mag held stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE, out_valid drops the next cycle.
  - No new input is accepted in ITER or DONE.
- Timing:
  - Latency: out_valid rises exactly ISIZE clock edges after the accepting edge.
  - Minimum initiation interval is ISIZE+2 cycles.
- Accuracy with default parameters: Angle within ±4 LSB of ideal. Mag within ±4 LSB of K*sqrt(X²+Y²), with K=1.64676.
- Mag never overflows DSIZE+1 bits: worst case is about 2.33*2**(DSIZE-1).

Test Plan (DSIZE=16, ISIZE=14, tolerance ±4 LSB):
- X=16384, Y=0 -> Angle≈0 (accept wrap 65532..65535), Mag≈26981; out_valid exactly 14 edges after accept.
- X=0,Y=16384 -> Angle≈16384, Mag≈26981; X=-16384,Y=0 -> Angle≈32768; X=0,Y=-16384 -> Angle≈49152.
- X=-32768, Y=0 -> Angle≈32768, Mag≈53961 (no overflow). X=-16384, Y=-16384 -> Angle≈40960, Mag≈38156.
- X=0, Y=0 -> Angle=0, Mag=0.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> Angle/Mag/out_valid constant and in_ready=0 throughout; out_ready=1 -> in_ready=1 next cycle.
- Pulse rst during ITER (cycle 5) -> next cycle in_ready=1, out_valid=0, Angle=0, Mag=0. A following sample X=16384, Y=16384 -> Angle≈8192, Mag≈38156.

Source files
------------

// File: rtl/xy_to_angle_iter_if.sv
// Handshake bundle for xy_to_angle_iter: X/Y input side and Angle/Mag
// output side, each with valid/ready. master = source/sink, slave = core.
interface xy_to_angle_iter_if #(
    parameter int DSIZE = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [DSIZE-1:0]   X;
    logic [DSIZE-1:0]   Y;
    logic               out_valid;
    logic               out_ready;
    logic [DSIZE-1:0]   Angle;
    logic [DSIZE:0]     Mag;

    modport master (
        output in_valid, X, Y, out_ready,
        input  in_ready, out_valid, Angle, Mag
    );

    modport slave (
        input  in_valid, X, Y, out_ready,
        output in_ready, out_valid, Angle, Mag
    );
endinterface

// File: rtl/xy_to_angle_iter.sv
// Iterative vectoring-mode CORDIC: signed (X,Y) -> unsigned phase + magnitude.
// Ports: clock, rst (sync, active-high), bus (slave: in/out valid-ready, X, Y, Angle, Mag).
module xy_to_angle_iter #(
    parameter int DSIZE = 16,
    parameter int PSIZE = 5,
    parameter int ISIZE = 14
) (
    input  logic              clock,
    input  logic              rst,
    xy_to_angle_iter_if.slave bus
);
    localparam int WW = DSIZE + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_n;
    logic [PSIZE-1:0]       r_cnt;
    logic signed [WW-1:0]   r_x;
    logic signed [WW-1:0]   r_y;
    logic [DSIZE-1:0]       r_z;
    logic                   r_zero;
    logic [DSIZE-1:0]       r_angle;
    logic [DSIZE:0]         r_mag;

    logic signed [WW-1:0]   w_xe;
    logic signed [WW-1:0]   w_ye;
    logic signed [WW-1:0]   w_xs;
    logic signed [WW-1:0]   w_ys;
    logic signed [WW-1:0]   w_x_n;
    logic signed [WW-1:0]   w_y_n;
    logic [DSIZE-1:0]       w_z_n;
    logic [DSIZE-1:0]       w_atan;
    logic                   w_last;

    // atan(2^-i) scaled to a 2^32 full circle
    function automatic logic [31:0] atan_rom(input logic [PSIZE-1:0] idx);
        logic [31:0] v;
        case (int'(idx))
            0:       v = 32'd536870912;
            1:       v = 32'd316933406;
            2:       v = 32'd167458907;
            3:       v = 32'd85004756;
            4:       v = 32'd42667331;
            5:       v = 32'd21354465;
            6:       v = 32'd10679838;
            7:       v = 32'd5340245;
            8:       v = 32'd2670163;
            9:       v = 32'd1335087;
            10:      v = 32'd667544;
            11:      v = 32'd333772;
            12:      v = 32'd166886;
            13:      v = 32'd83443;
            14:      v = 32'd41722;
            15:      v = 32'd20861;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    // Round-half-up down to DSIZE bits of circle
    function automatic logic [DSIZE-1:0] atan_q(input logic [PSIZE-1:0] idx);
        logic [32:0] t;
        t = {1'b0, atan_rom(idx)};
        if (DSIZE < 32)
            t = (t + (33'd1 << (31 - DSIZE))) >> (32 - DSIZE);
        return t[DSIZE-1:0];
    endfunction

    // Sign-extend first so negating -2^(DSIZE-1) stays exact
    assign w_xe   = {{2{bus.X[DSIZE-1]}}, bus.X};
    assign w_ye   = {{2{bus.Y[DSIZE-1]}}, bus.Y};
    assign w_xs   = r_x >>> r_cnt;
    assign w_ys   = r_y >>> r_cnt;
    assign w_atan = atan_q(r_cnt);
    assign w_last = (r_cnt == PSIZE'(ISIZE - 1));

    always_comb begin
        w_x_n = r_x;
        w_y_n = r_y;
        w_z_n = r_z;
        if (!r_y[WW-1]) begin
            w_x_n = r_x + w_ys;
            w_y_n = r_y - w_xs;
            w_z_n = r_z + w_atan;
        end else begin
            w_x_n = r_x - w_ys;
            w_y_n = r_y + w_xs;
            w_z_n = r_z - w_atan;
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_state_n = S_ITER;
            S_ITER:  if (w_last) w_state_n = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_zero  <= 1'b0;
            r_angle <= '0;
            r_mag   <= '0;
        end else begin
            r_state <= w_state_n;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_cnt  <= '0;
                        r_zero <= (bus.X == '0) && (bus.Y == '0);
                        if (bus.X[DSIZE-1]) begin
                            // Pre-rotate by 180 deg into the right half-plane
                            r_x <= -w_xe;
                            r_y <= -w_ye;
                            r_z <= {1'b1, {(DSIZE-1){1'b0}}};
                        end else begin
                            r_x <= w_xe;
                            r_y <= w_ye;
                            r_z <= '0;
                        end
                    end
                end
                S_ITER: begin
                    r_x   <= w_x_n;
                    r_y   <= w_y_n;
                    r_z   <= w_z_n;
                    r_cnt <= r_cnt + PSIZE'(1);
                    if (w_last) begin
                        // Zero vector has no defined phase; report 0/0
                        r_angle <= r_zero ? '0 : w_z_n;
                        r_mag   <= r_zero ? '0 : w_x_n[DSIZE:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.Angle     = r_angle;
    assign bus.Mag       = r_mag;
endmodule

// File: tb/tb_xy_to_angle_iter.sv
// Directed self-checking bench for xy_to_angle_iter.
// Ports exercised: clock, rst, full in/out handshake via the interface.
module tb_xy_to_angle_iter;
    localparam int DSIZE = 16;
    localparam int ISIZE = 14;
    localparam int TOL   = 4;

    logic clock;
    logic rst;
    int   errors;
    int   checks;

    xy_to_angle_iter_if #(.DSIZE(DSIZE)) bus ();

    xy_to_angle_iter #(
        .DSIZE(DSIZE),
        .PSIZE(5),
        .ISIZE(ISIZE)
    ) dut (
        .clock(clock),
        .rst  (rst),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Angle compared modulo the full circle
    task automatic chk_ang(input string tag, input int obs, input int exp);
        int d;
        logic ok;
        d  = (obs - exp) & 32'hFFFF;
        ok = (d <= TOL) || (d >= 65536 - TOL);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, TOL);
        end
    endtask

    task automatic chk_mag(input string tag, input int obs, input int exp);
        int d;
        logic ok;
        d  = obs - exp;
        ok = (d <= TOL) && (d >= -TOL);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, TOL);
        end
    endtask

    // Present one sample, wait for accept, then count edges to out_valid
    task automatic send(input int x, input int y, output int lat);
        lat = 0;
        bus.X        = DSIZE'(x);
        bus.Y        = DSIZE'(y);
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic vec(input string tag, input int x, input int y,
                       input int ea, input int em, input logic exact);
        int lat;
        chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
        send(x, y, lat);
        chk({tag, "_latency"}, lat, ISIZE);
        if (exact) begin
            chk({tag, "_angle"}, int'(bus.Angle), ea);
            chk({tag, "_mag"}, int'(bus.Mag), em);
        end else begin
            chk_ang({tag, "_angle"}, int'(bus.Angle), ea);
            chk_mag({tag, "_mag"}, int'(bus.Mag), em);
        end
        drain();
    endtask

    initial begin
        int   lat;
        int   a0;
        int   m0;
        logic stable;

        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.X         = '0;
        bus.Y         = '0;
        repeat (3) @(posedge clock);
        #1;
        rst = 1'b0;

        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_angle", int'(bus.Angle), 0);
        chk("rst_mag", int'(bus.Mag), 0);

        vec("px", 16384, 0, 0, 26981, 1'b0);
        vec("py", 0, 16384, 16384, 26981, 1'b0);
        vec("nx", -16384, 0, 32768, 26981, 1'b0);
        vec("ny", 0, -16384, 49152, 26981, 1'b0);
        vec("nxmax", -32768, 0, 32768, 53961, 1'b0);
        vec("q3", -16384, -16384, 40960, 38156, 1'b0);
        vec("zero", 0, 0, 0, 0, 1'b1);

        // Backpressure: hold result for 20 cycles
        send(16384, 16384, lat);
        chk("bp_latency", lat, ISIZE);
        a0     = int'(bus.Angle);
        m0     = int'(bus.Mag);
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            if (int'(bus.Angle) != a0 || int'(bus.Mag) != m0 ||
                bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                stable = 1'b0;
        end
        chk("bp_stable", int'(stable), 1);
        chk_ang("bp_angle", a0, 8192);
        drain();
        chk("bp_in_ready_after", int'(bus.in_ready), 1);
        chk("bp_out_valid_after", int'(bus.out_valid), 0);

        // Reset in the middle of iteration
        bus.X        = DSIZE'(-16384);
        bus.Y        = DSIZE'(16384);
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("mid_busy", int'(bus.in_ready), 0);
        rst = 1'b1;
        @(posedge clock);
        #1;
        rst = 1'b0;
        chk("mid_in_ready", int'(bus.in_ready), 1);
        chk("mid_out_valid", int'(bus.out_valid), 0);
        chk("mid_angle", int'(bus.Angle), 0);
        chk("mid_mag", int'(bus.Mag), 0);

        vec("post_rst", 16384, 16384, 8192, 38156, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
